// File: rtl/reg_file_mp.sv
// Multi-port integer register file with per-register busy scoreboard for the RV32I core.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data and busy state to the read ports.
module reg_file_mp #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    localparam int AW          = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]      rd_reg,
    output logic [NUM_RD_PORTS-1:0][XLEN-1:0]    rd_data,
    output logic [NUM_RD_PORTS-1:0]              rd_busy,
    input  logic [NUM_WR_PORTS-1:0]              wr_en,
    input  logic [NUM_WR_PORTS-1:0][AW-1:0]      wr_reg,
    input  logic [NUM_WR_PORTS-1:0][XLEN-1:0]    wr_data,
    input  logic                                 alloc_en,
    input  logic [AW-1:0]                        alloc_reg
);

    logic [XLEN-1:0]                 regs [NUM_REGS];
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             wr_hit;
    logic [NUM_REGS-1:0][XLEN-1:0]   wr_val;
    logic [NUM_REGS-1:0]             alloc_hit;

    // Ports are scanned in ascending order so the highest-index port wins a collision.
    // Entry 0 is never hit, which keeps x0 and out-of-range addresses immune.
    always_comb begin
        wr_hit    = '0;
        wr_val    = '0;
        alloc_hit = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en[p] && (wr_reg[p] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[p];
                end
            end
            alloc_hit[r] = alloc_en && (alloc_reg == AW'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
                // An allocate belongs to a younger producer than any same-cycle write.
                if (alloc_hit[r]) begin
                    busy[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if ((rd_reg[p] != '0) && (int'(rd_reg[p]) < NUM_REGS)) begin
                rd_data[p] = regs[rd_reg[p]];
                rd_busy[p] = busy[rd_reg[p]];
`ifdef REG_FILE_BYPASS_EN
                if (wr_hit[rd_reg[p]]) begin
                    rd_data[p] = wr_val[rd_reg[p]];
                    rd_busy[p] = alloc_hit[rd_reg[p]];
                end
`endif
            end
        end
    end

endmodule
